grf_wb_queue: RTL and testbench

- Write-side companion to the general register file (GRF).
- Accepts register-writeback requests from the pipeline, buffers them in a small in-order FIFO, and drains one per cycle onto the GRF write port (RegWrite/A3/WD/PC).
- Provides two combinational lookup ports, so readers can see pending, not-yet-committed values (newest wins) while the GRF is stalled by Drain_En=0.

---
 rtl/grf_wb_queue.sv | 132 +++++++++++++
 tb/tb_grf_wb_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_queue.sv
// In-order writeback queue in front of the GRF write port. Buffers register writes while the
// GRF is stalled and exposes the newest pending value per register through two lookup ports.
module grf_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [4:0]               In_A3,
  input  logic [DW-1:0]            In_WD,
  input  logic [DW-1:0]            In_PC,
  input  logic                     Drain_En,
  output logic                     RegWrite,
  output logic [4:0]               A3,
  output logic [DW-1:0]            WD,
  output logic [DW-1:0]            PC,
  input  logic [4:0]               Q_A1,
  output logic                     Q_Hit1,
  output logic [DW-1:0]            Q_D1,
  input  logic [4:0]               Q_A2,
  output logic                     Q_Hit2,
  output logic [DW-1:0]            Q_D2,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]    a3_q [DEPTH];
  logic [4:0]    a3_d [DEPTH];
  logic [DW-1:0] wd_q [DEPTH];
  logic [DW-1:0] wd_d [DEPTH];
  logic [DW-1:0] pc_q [DEPTH];
  logic [DW-1:0] pc_d [DEPTH];

  logic          push;
  logic          store;
  logic          pop;
  logic [AW-1:0] lk_idx;

  // Ready depends only on occupancy, never on this cycle's drain.
  assign In_Ready = (count_q != CW'(DEPTH));
  assign RegWrite = (count_q != '0) && Drain_En;
  assign Count    = count_q;

  assign push  = In_Valid && In_Ready;
  // Writes to r0 complete the handshake but are dropped.
  assign store = push && (In_A3 != 5'd0);
  assign pop   = RegWrite;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    a3_d    = a3_q;
    wd_d    = wd_q;
    pc_d    = pc_q;
    if (store) begin
      a3_d[tail_q] = In_A3;
      wd_d[tail_q] = In_WD;
      pc_d[tail_q] = In_PC;
      tail_d       = tail_q + AW'(1);
    end
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    unique case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: only entries covered by count_q are ever observed.
  always_ff @(posedge Clk) begin
    a3_q <= a3_d;
    wd_q <= wd_d;
    pc_q <= pc_d;
  end

  always_comb begin
    A3 = '0;
    WD = '0;
    PC = '0;
    if (count_q != '0) begin
      A3 = a3_q[head_q];
      WD = wd_q[head_q];
      PC = pc_q[head_q];
    end
  end

  // Walk oldest to newest so the last match (the newest) wins.
  always_comb begin
    Q_Hit1 = 1'b0;
    Q_D1   = '0;
    Q_Hit2 = 1'b0;
    Q_D2   = '0;
    lk_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if ((Q_A1 != 5'd0) && (a3_q[lk_idx] == Q_A1)) begin
          Q_Hit1 = 1'b1;
          Q_D1   = wd_q[lk_idx];
        end
        if ((Q_A2 != 5'd0) && (a3_q[lk_idx] == Q_A2)) begin
          Q_Hit2 = 1'b1;
          Q_D2   = wd_q[lk_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Self-checking bench for grf_wb_queue: a directed vector table plus hand-written sequences
// for wrap-around streaming and asynchronous reset in the middle of a drain.
module tb_grf_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_a3;
  logic [31:0] in_wd;
  logic [31:0] in_pc;
  logic        drain_en;
  logic        reg_write;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [4:0]  q_a1;
  logic        q_hit1;
  logic [31:0] q_d1;
  logic [4:0]  q_a2;
  logic        q_hit2;
  logic [31:0] q_d2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  grf_wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .Clk      (clk),
    .Reset    (rst),
    .In_Valid (in_valid),
    .In_Ready (in_ready),
    .In_A3    (in_a3),
    .In_WD    (in_wd),
    .In_PC    (in_pc),
    .Drain_En (drain_en),
    .RegWrite (reg_write),
    .A3       (a3),
    .WD       (wd),
    .PC       (pc),
    .Q_A1     (q_a1),
    .Q_Hit1   (q_hit1),
    .Q_D1     (q_d1),
    .Q_A2     (q_a2),
    .Q_Hit2   (q_hit2),
    .Q_D2     (q_d2),
    .Count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        dr;
    logic [4:0]  qa1;
    logic [4:0]  qa2;
    logic        rw;
    logic [4:0]  oa3;
    logic [31:0] owd;
    logic [31:0] opc;
    logic [2:0]  cnt;
    logic        rdy;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] v, a3i, wdi, pci, dr, qa1, qa2,
                              input logic [31:0] rw, oa3, owd, opc, cnt, rdy, h1, d1, h2, d2);
    vec_t m;
    m.v   = v[0];
    m.a3  = a3i[4:0];
    m.wd  = wdi;
    m.pc  = pci;
    m.dr  = dr[0];
    m.qa1 = qa1[4:0];
    m.qa2 = qa2[4:0];
    m.rw  = rw[0];
    m.oa3 = oa3[4:0];
    m.owd = owd;
    m.opc = opc;
    m.cnt = cnt[2:0];
    m.rdy = rdy[0];
    m.h1  = h1[0];
    m.d1  = d1;
    m.h2  = h2[0];
    m.d2  = d2;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_a3    = '0;
    in_wd    = '0;
    in_pc    = '0;
    drain_en = 1'b0;
    q_a1     = '0;
    q_a2     = '0;
  endtask

  vec_t vecs[$];
  logic [4:0]  m_a3[$];
  logic [31:0] m_wd[$];
  logic [31:0] m_pc[$];

  initial begin
    vec_t  t;
    int    k;
    logic  exp_rdy;
    int    sz;

    // Commit path, full/refused push, newest-wins lookup, r0 drop.
    vecs.push_back(mk(1, 5, 'h1234, 'h3000, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 1, 5, 'h1234, 'h3000, 1, 1, 1, 'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h101, 'h4001, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 'h102, 'h4002, 0, 1, 2, 0, 1, 'h101, 'h4001, 1, 1, 1, 'h101, 0, 0));
    vecs.push_back(mk(1, 3, 'h103, 'h4003, 0, 2, 3, 0, 1, 'h101, 'h4001, 2, 1, 1, 'h102, 0, 0));
    vecs.push_back(mk(1, 4, 'h104, 'h4004, 0, 3, 1, 0, 1, 'h101, 'h4001, 3, 1, 1, 'h103, 1,
                      'h101));
    vecs.push_back(mk(1, 9, 'h999, 'h4009, 0, 4, 9, 0, 1, 'h101, 'h4001, 4, 0, 1, 'h104, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 9, 4, 1, 1, 'h101, 'h4001, 4, 0, 0, 0, 1, 'h104));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 2, 'h102, 'h4002, 3, 1, 1, 'h102, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 1, 3, 'h103, 'h4003, 2, 1, 1, 'h103, 1, 'h104));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 3, 1, 4, 'h104, 'h4004, 1, 1, 1, 'h104, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 'hAAAA, 'h5000, 0, 7, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 'hBBBB, 'h5004, 0, 7, 8, 0, 7, 'hAAAA, 'h5000, 1, 1, 1, 'hAAAA, 0,
                      0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8, 0, 7, 'hAAAA, 'h5000, 2, 1, 1, 'hBBBB, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 8, 1, 7, 'hAAAA, 'h5000, 2, 1, 1, 'hBBBB, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8, 0, 7, 'hBBBB, 'h5004, 1, 1, 1, 'hBBBB, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 8, 1, 7, 'hBBBB, 'h5004, 1, 1, 1, 'hBBBB, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 'hFFFF, 'h6000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    idle_inputs();
    rst = 1'b1;
    drain_en = 1'b1;
    #2;
    chk("reset_count", 32'(count), 0);
    chk("reset_ready", 32'(in_ready), 1);
    chk("reset_regwrite", 32'(reg_write), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      t = vecs[i];
      in_valid = t.v;
      in_a3    = t.a3;
      in_wd    = t.wd;
      in_pc    = t.pc;
      drain_en = t.dr;
      q_a1     = t.qa1;
      q_a2     = t.qa2;
      #2;
      chk($sformatf("v%0d_regwrite", i), 32'(reg_write), 32'(t.rw));
      chk($sformatf("v%0d_a3", i), 32'(a3), 32'(t.oa3));
      chk($sformatf("v%0d_wd", i), wd, t.owd);
      chk($sformatf("v%0d_pc", i), pc, t.opc);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(t.cnt));
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(t.rdy));
      chk($sformatf("v%0d_hit1", i), 32'(q_hit1), 32'(t.h1));
      chk($sformatf("v%0d_d1", i), q_d1, t.d1);
      chk($sformatf("v%0d_hit2", i), 32'(q_hit2), 32'(t.h2));
      chk($sformatf("v%0d_d2", i), q_d2, t.d2);
    end

    // Fill with drain off, then stream 8 cycles with drain on: pointers wrap, order kept.
    k = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      idle_inputs();
      sz       = m_a3.size();
      exp_rdy  = (sz != DEPTH);
      drain_en = (cyc >= 4);
      in_valid = (cyc < 12);
      in_a3    = 5'(1 + (k % 31));
      in_wd    = 32'hC000 + 32'(k);
      in_pc    = 32'hD000 + 32'(k);
      #2;
      chk($sformatf("wrap%0d_count", cyc), 32'(count), 32'(sz));
      chk($sformatf("wrap%0d_ready", cyc), 32'(in_ready), 32'(exp_rdy));
      chk($sformatf("wrap%0d_regwrite", cyc), 32'(reg_write), 32'(drain_en && (sz != 0)));
      if (sz != 0) begin
        chk($sformatf("wrap%0d_a3", cyc), 32'(a3), 32'(m_a3[0]));
        chk($sformatf("wrap%0d_wd", cyc), wd, m_wd[0]);
        chk($sformatf("wrap%0d_pc", cyc), pc, m_pc[0]);
        if (drain_en) begin
          void'(m_a3.pop_front());
          void'(m_wd.pop_front());
          void'(m_pc.pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        m_a3.push_back(in_a3);
        m_wd.push_back(in_wd);
        m_pc.push_back(in_pc);
        k++;
      end
      if (cyc >= 12 && m_a3.size() == 0) break;
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("wrap_drained_count", 32'(count), 32'(m_a3.size()));
    chk("wrap_accepted", 32'(k), 11);

    // Three pending entries, then an asynchronous reset pulse inside the low phase.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      idle_inputs();
      in_valid = 1'b1;
      in_a3    = 5'(20 + j);
      in_wd    = 32'hE000 + 32'(j);
      in_pc    = 32'hF000 + 32'(j);
    end
    @(negedge clk);
    idle_inputs();
    drain_en = 1'b1;
    q_a1     = 5'd20;
    #1;
    chk("prerst_count", 32'(count), 3);
    chk("prerst_regwrite", 32'(reg_write), 1);
    chk("prerst_hit1", 32'(q_hit1), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_regwrite", 32'(reg_write), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_hit1", 32'(q_hit1), 0);
    #1 rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #2;
      chk($sformatf("postrst%0d_regwrite", j), 32'(reg_write), 0);
      chk($sformatf("postrst%0d_count", j), 32'(count), 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_a3    = 5'd25;
    in_wd    = 32'h7777;
    in_pc    = 32'h8888;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("fresh_regwrite", 32'(reg_write), 1);
    chk("fresh_a3", 32'(a3), 25);
    chk("fresh_wd", wd, 32'h7777);
    chk("fresh_pc", pc, 32'h8888);
    @(negedge clk);
    #2;
    chk("fresh_done_count", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
